pkt_dvdr_tx_arbiter: RTL and testbench
======================================

# pkt_dvdr_tx_arbiter

Round-robin packet arbiter that shares the single packet-divider transmit byte stream (`tx_en`/`tx_data`) among `NUM_REQ` requesters. Each requester offers a framed packet as a byte stream (sop, len, data, padding, parity, eop) with a valid/ready handshake. The arbiter grants one requester per packet and forwards its bytes to the transmit interface with one cycle of latency. It enforces an inter-packet gap, aborts requesters that stall mid-packet, and can optionally check parity.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `IPG`, 2: idle cycles with `tx_en` low after each packet or abort, 0..15.
- `TIMEOUT`, 16: consecutive stalled cycles mid-packet before abort, 1..255.

- `clk` input 1: clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input NUM_REQ: requester i has a byte on its `in_data` slice.
- `in_data` input 8*NUM_REQ: byte for requester i on bits [8i+7:8i].
- `in_last` input NUM_REQ: the byte is eop, the last byte of the packet.
- `in_ready` output NUM_REQ: the byte from requester i is accepted this cycle.
- `tx_en` output 1: transmit byte valid.
- `tx_data` output 8: transmit byte.
- `grant` output NUM_REQ: one-hot owner of the stream, all zero when idle.
- `busy` output 1: high in FWD or GAP.
- `abort` output 1: one-cycle pulse when a timeout ends a packet.
- `parity_err` output 1: one-cycle pulse on a bad parity byte (macro only).

## Operation
- **States:** IDLE, FWD, GAP.
- **IDLE:**
  - If any `in_valid` is high, select the first requester at or after `rr_ptr` (wrapping modulo NUM_REQ).
  - Register `grant` and go to FWD. No bytes are accepted in the arbitration cycle.
- **FWD:**
  - `in_ready[g]` = `in_valid[g]` combinationally; every other `in_ready` bit is 0.
  - An accepted byte is registered onto `tx_data` with `tx_en`=1 on the next cycle. Otherwise `tx_en`=0 and `tx_data` holds its last value.
  - On an accepted byte with `in_last[g]`: set `rr_ptr` = g+1 (wrapping), clear `grant`, and go to GAP. If IPG=0, go to IDLE instead.
- **Stall counter:**
  - Counts consecutive FWD cycles with `in_valid[g]`=0 and resets to 0 on every accepted byte.
  - When it reaches TIMEOUT: pulse `abort`, set `rr_ptr` = g+1, clear `grant`, and go to GAP (or IDLE if IPG=0).
  - Bytes the requester presents after an abort belong to a new arbitration.
- **GAP:** count IPG cycles with `tx_en`=0, then go to IDLE.
- **Packet length:** the arbiter does not interpret the length byte. `in_last` alone delimits the packet; a single-byte packet is legal.
- **Fairness:** a requester that was just served or aborted has the lowest priority in the next arbitration.

## Timing
- **Reset values:** every output is 0, `rr_ptr`=0, state IDLE, counters 0.
- Asserting `rst` mid-packet forces `tx_en`=0 on the next edge. The partial packet is dropped and no `abort` pulse is generated.
- **Latency:**
  - 1 cycle from `in_valid` rising in IDLE to `grant`.
  - First `in_ready` in the cycle after `grant` rises.
  - 1 cycle from acceptance to `tx_en`.
- **Back-to-back traffic:** with continuous traffic the minimum spacing is the eop byte on tx, then IPG cycles of gap, 1 arbitration cycle, and 1 pipeline cycle before the next sop byte on tx. With IPG=2 that is 4 cycles with `tx_en` low between the eop byte and the next sop.
- **Simultaneous events:**
  - `in_last` acceptance and timeout cannot coincide, because acceptance clears the counter.
  - Requests arriving during GAP wait for IDLE.
- **Counter widths:** stall counter 8 bits, gap counter 4 bits, `rr_ptr` $clog2(NUM_REQ) bits.

## Configuration
- **`PKT_DVDR_TX_ARB_PARITY_CHK_EN` defined:**
  - The arbiter keeps a running XOR of accepted bytes from the second byte (len) up to and including the third-from-last byte.
  - It keeps a one-byte delay register so the second-to-last byte is taken as the parity byte.
  - When eop is accepted, a mismatch pulses `parity_err` in the cycle eop appears on `tx_en`.
  - Packets shorter than 4 bytes and aborted packets are not checked.
- **Macro not defined:** the parity logic is removed and `parity_err` is tied to 0.

## Test plan
- Reset: hold `rst` for 3 cycles with all `in_valid`=1 → every output 0. Then `grant`=4'b0001 on the first cycle after release, i.e. 1 cycle after `rst` falls.
- Single packet: requester 2 sends 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, parity 8'h03, eop 8'h5A → `tx_data` reproduces all 7 bytes in order, each 1 cycle after its `in_ready`. `grant` clears after eop; `busy` drops after 2 GAP cycles.
- Round robin: all 4 requesters continuously valid with 3-byte packets → grant order 0,1,2,3,0, with 4 idle `tx_en` cycles between packets.
- Timeout: requester 1 sends 2 bytes, then holds `in_valid` low for 16 cycles → `abort` pulses once, `grant` clears, and requester 3 (waiting) is granted next.
- Reset mid-packet: `rst` asserted on the 3rd data byte → `tx_en`=0 on the next cycle, `grant`=0, and arbitration restarts from requester 0.
- Parity (macro on): same packet as the single-packet scenario but parity byte 8'h04 → `parity_err` pulses exactly once, aligned with the eop byte on tx. With parity byte 8'h03 it stays 0.

Source files
------------

// File: rtl/pkt_dvdr_tx_arbiter.sv
// Round-robin arbiter sharing the packet-divider tx byte stream among NUM_REQ requesters.
// Optional parity checking is compiled in with `define PKT_DVDR_TX_ARB_PARITY_CHK_EN.
module pkt_dvdr_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IPG     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     in_valid,
    input  logic [8*NUM_REQ-1:0]   in_data,
    input  logic [NUM_REQ-1:0]     in_last,
    output logic [NUM_REQ-1:0]     in_ready,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   abort,
    output logic                   parity_err
);
    localparam int         PW        = $clog2(NUM_REQ);
    localparam logic [3:0] GAP_LAST  = (IPG > 0) ? 4'(IPG - 1) : 4'd0;
    localparam logic [7:0] STALL_MAX = 8'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt, gidx, gidx_nxt, gidx_inc, sel_idx, cand;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [7:0]         stall_cnt, stall_cnt_nxt, cur_byte;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic               sel_found, accept, acc_last, abort_nxt;
    int                 pos;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        pos       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            cand = PW'(pos);
            if (!sel_found && in_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state == S_FWD) in_ready[gidx] = in_valid[gidx];
    end

    assign accept   = (state == S_FWD) && in_valid[gidx];
    assign acc_last = accept && in_last[gidx];
    assign cur_byte = in_data[{gidx, 3'b000} +: 8];
    assign gidx_inc = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        gidx_nxt      = gidx;
        rr_ptr_nxt    = rr_ptr;
        stall_cnt_nxt = stall_cnt;
        gap_cnt_nxt   = gap_cnt;
        abort_nxt     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_found) begin
                    state_nxt          = S_FWD;
                    gidx_nxt           = sel_idx;
                    grant_nxt          = '0;
                    grant_nxt[sel_idx] = 1'b1;
                    stall_cnt_nxt      = '0;
                end
            end
            S_FWD: begin
                stall_cnt_nxt = accept ? 8'd0 : stall_cnt + 8'd1;
                // Packet ends on eop acceptance or on stall timeout; either way the owner drops to lowest priority.
                if (acc_last || (!accept && (stall_cnt + 8'd1 == STALL_MAX))) begin
                    abort_nxt     = !accept;
                    rr_ptr_nxt    = gidx_inc;
                    grant_nxt     = '0;
                    gap_cnt_nxt   = '0;
                    stall_cnt_nxt = '0;
                    state_nxt     = (IPG == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                // The eop byte still on tx does not count as a gap cycle.
                if (!tx_en) begin
                    if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
                    else gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant     <= '0;
            gidx      <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            abort     <= 1'b0;
            tx_en     <= 1'b0;
            tx_data   <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            gidx      <= gidx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            stall_cnt <= stall_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            abort     <= abort_nxt;
            tx_en     <= accept;
            if (accept) tx_data <= cur_byte;
        end
    end

`ifdef PKT_DVDR_TX_ARB_PARITY_CHK_EN
    logic [7:0] par_acc, par_dly;
    logic [2:0] par_cnt;

    // par_dly lags one byte so that at eop it holds the parity byte; par_acc folds bytes 2..N-2.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_cnt    <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == S_IDLE) begin
                par_cnt <= '0;
            end else if (accept) begin
                par_dly <= cur_byte;
                if (par_cnt != 3'd7) par_cnt <= par_cnt + 3'd1;
                if (par_cnt == 3'd0) par_acc <= '0;
                else if (acc_last) parity_err <= (par_cnt >= 3'd3) && (par_acc != par_dly);
                else if (par_cnt >= 3'd2) par_acc <= par_acc ^ par_dly;
            end
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_dvdr_tx_arbiter.sv
// Directed-vector bench for pkt_dvdr_tx_arbiter (NUM_REQ=4, IPG=2, TIMEOUT=16).
module tb_pkt_dvdr_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid, in_last, in_ready, grant;
    logic [8*N-1:0] in_data;
    logic           tx_en, busy, abort, parity_err;
    logic [7:0]     tx_data;

    int         n_chk = 0;
    int         n_pass = 0;
    int         perr_cnt = 0;
    logic       perr_at_eop;
    logic [7:0] pkt [7];

    always #5 clk = ~clk;

    pkt_dvdr_tx_arbiter #(.NUM_REQ(N), .IPG(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .tx_en(tx_en), .tx_data(tx_data), .grant(grant),
        .busy(busy), .abort(abort), .parity_err(parity_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (parity_err) perr_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
        tick(); tick();
        rst = 1'b0;
        perr_cnt = 0;
    endtask

    // Sends pkt[0..6] from requester r starting in IDLE; leaves the bench just after eop is on tx.
    task automatic send_pkt(input int r, input string tag);
        in_valid = '0; in_last = '0;
        in_valid[r] = 1'b1;
        in_data[8*r +: 8] = pkt[0];
        tick();
        check({tag, "_grant"}, grant, 32'(1 << r));
        check({tag, "_tx_idle"}, tx_en, 0);
        for (int i = 0; i < 7; i++) begin
            in_data[8*r +: 8] = pkt[i];
            in_last[r] = (i == 6);
            #1;
            check($sformatf("%s_rdy%0d", tag, i), in_ready, 32'(1 << r));
            tick();
            check($sformatf("%s_tx%0d", tag, i), {tx_en, tx_data}, {1'b1, pkt[i]});
        end
        perr_at_eop = parity_err;
        in_valid = '0; in_last = '0;
    endtask

    int         cnt [N];
    logic [3:0] rdy, prev_g;
    logic [3:0] gr_seen [8];
    int         gaps [8];
    int         n_gr, n_gap, n_tx, low_run, early;

    initial begin
        // Reset held with all requesters valid.
        rst = 1'b1; in_valid = '1; in_last = '0; in_data = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", {tx_en, tx_data, grant, busy, abort, parity_err, in_ready}, 0);
        end
        rst = 1'b0;
        tick();
        check("rst_first_grant", grant, 4'b0001);
        check("rst_busy", busy, 1);
        do_reset();

        // Single packet from requester 2.
        pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h5A};
        send_pkt(2, "sp");
        check("sp_grant_clr", grant, 0);
        check("sp_busy_gap0", busy, 1);
        tick();
        check("sp_gap1", {tx_en, busy}, 2'b01);
        tick();
        check("sp_gap2", {tx_en, busy}, 2'b01);
        tick();
        check("sp_idle", busy, 0);
        check("sp_no_perr", perr_cnt, 0);

        // Reset mid-packet; rr_ptr is 3 here, so a grant of 0 afterwards proves it was cleared.
        in_valid = 4'b0100; in_data[23:16] = pkt[0];
        tick();
        check("rm_grant", grant, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            in_data[23:16] = pkt[i];
            tick();
            check($sformatf("rm_tx%0d", i), {tx_en, tx_data}, {1'b1, pkt[i]});
        end
        in_data[23:16] = pkt[2];
        rst = 1'b1;
        tick();
        check("rm_after_rst", {tx_en, grant, abort, busy}, 0);
        rst = 1'b0; in_valid = '1;
        tick();
        check("rm_restart_grant", grant, 4'b0001);
        do_reset();

        // Timeout: requester 1 stalls after two bytes while requester 3 waits.
        in_valid = 4'b1010; in_data[15:8] = 8'hC1; in_data[31:24] = 8'hD0;
        tick();
        check("to_grant", grant, 4'b0010);
        for (int i = 0; i < 2; i++) begin
            in_data[15:8] = 8'hC1 + 8'(i);
            #1;
            check("to_rdy", in_ready, 4'b0010);
            tick();
            check("to_tx", {tx_en, tx_data}, {1'b1, 8'hC1 + 8'(i)});
        end
        in_valid[1] = 1'b0;
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (abort || tx_en || grant != 4'b0010) early++;
        end
        check("to_stall_hold", early, 0);
        tick();
        check("to_abort", abort, 1);
        check("to_grant_clr", grant, 0);
        in_valid[1] = 1'b1;
        tick();
        check("to_abort_once", {abort, busy}, 2'b01);
        tick();
        check("to_gap_grant", grant, 0);
        tick();
        check("to_next_grant", grant, 4'b1000);
        do_reset();

        // Round robin: everyone always valid with 3-byte packets.
        for (int i = 0; i < N; i++) cnt[i] = 0;
        in_valid = '1;
        n_gr = 0; n_gap = 0; n_tx = 0; low_run = 0; prev_g = '0;
        for (int cyc = 0; cyc < 80 && n_tx < 15; cyc++) begin
            for (int i = 0; i < N; i++) begin
                in_data[8*i +: 8] = 8'(16 * i + cnt[i]);
                in_last[i] = (cnt[i] == 2);
            end
            #1;
            rdy = in_ready;
            tick();
            for (int i = 0; i < N; i++)
                if (rdy[i]) cnt[i] = (cnt[i] == 2) ? 0 : cnt[i] + 1;
            if (grant != 0 && grant != prev_g && n_gr < 8) begin
                gr_seen[n_gr] = grant;
                n_gr++;
            end
            prev_g = grant;
            if (tx_en) begin
                if (n_tx > 0 && low_run > 0 && n_gap < 8) begin
                    gaps[n_gap] = low_run;
                    n_gap++;
                end
                check($sformatf("rr_tx%0d", n_tx), tx_data, 8'(16 * ((n_tx / 3) % 4) + n_tx % 3));
                n_tx++;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
        check("rr_ntx", n_tx, 15);
        check("rr_ngrant", n_gr, 5);
        check("rr_order", {gr_seen[0], gr_seen[1], gr_seen[2], gr_seen[3], gr_seen[4]},
              {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001});
        check("rr_ngap", n_gap, 4);
        for (int i = 0; i < 4; i++) check($sformatf("rr_gap%0d", i), gaps[i], 4);
        do_reset();

`ifdef PKT_DVDR_TX_ARB_PARITY_CHK_EN
        // Bad parity byte, then a good one.
        pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04, 8'h5A};
        send_pkt(2, "pb");
        check("pb_perr_at_eop", perr_at_eop, 1);
        tick(); tick(); tick();
        check("pb_perr_count", perr_cnt, 1);
        perr_cnt = 0;
        pkt[5] = 8'h03;
        send_pkt(2, "pg");
        tick(); tick(); tick();
        check("pg_perr_at_eop", perr_at_eop, 0);
        check("pg_perr_count", perr_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
